// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - pipeline stall/flush controller for the five-stage core
//
// Purpose: detects load-use hazards and holds the front end for fixed-latency
// multi-cycle EX ops. It squashes the fetched instruction on a taken branch
// and counts bubble cycles in a saturating statistic.
//
// Ports:
//   Clk, Rst        clock, synchronous active-high reset
//   ID_Rs, ID_Rt    source register fields of the ID instruction
//   ID_UsesRt       ID instruction reads rt
//   ID_MultiCycle   ID instruction is a multi-cycle EX op
//   EX_MemRead      EX instruction is a load
//   EX_WriteReg     EX instruction destination register
//   BranchTaken     branch/jump resolved taken in ID
//   StatClear       synchronous clear of StallCycles
//   HazardControl   1 = zero ID/EX control (bubble)
//   PCWrite         PC write enable
//   IFIDWrite       IF/ID write enable
//   IFIDFlush       IF/ID loads NOP
//   Busy            multi-cycle hold in progress
//   StallCycles     saturating count of bubble cycles
module hazard_stall_controller #(
  parameter int MC_LATENCY = 4,
  parameter int STAT_W     = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [4:0]        ID_Rs,
  input  logic [4:0]        ID_Rt,
  input  logic              ID_UsesRt,
  input  logic              ID_MultiCycle,
  input  logic              EX_MemRead,
  input  logic [4:0]        EX_WriteReg,
  input  logic              BranchTaken,
  input  logic              StatClear,
  output logic              HazardControl,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              IFIDFlush,
  output logic              Busy,
  output logic [STAT_W-1:0] StallCycles
);

  typedef enum logic {
    RUN     = 1'b0,
    MC_HOLD = 1'b1
  } state_t;

  // A latency of 1 means the op completes like any other; no hold is needed.
  localparam bit              HOLD_EN   = (MC_LATENCY > 1);
  localparam logic [3:0]      HOLD_LOAD = 4'(MC_LATENCY - 1);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       lu;

  // $0 is hardwired, so a load targeting it never creates a dependency.
  assign lu = EX_MemRead && (EX_WriteReg != 5'd0) &&
              ((EX_WriteReg == ID_Rs) || (ID_UsesRt && (EX_WriteReg == ID_Rt)));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        // A stalled multi-cycle op is not yet leaving ID, so it only arms the
        // hold on the cycle it actually advances.
        if (HOLD_EN && !lu && ID_MultiCycle) begin
          state_nxt = MC_HOLD;
          cnt_nxt   = HOLD_LOAD;
        end
      end
      MC_HOLD: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_comb begin
    HazardControl = 1'b1;
    PCWrite       = 1'b0;
    IFIDWrite     = 1'b0;
    IFIDFlush     = 1'b0;
    Busy          = 1'b0;
    if (!Rst) begin
      case (state)
        MC_HOLD: begin
          Busy = 1'b1;
        end
        default: begin
          // A stalled branch is not flushed; it is re-evaluated next cycle.
          if (!lu) begin
            HazardControl = 1'b0;
            PCWrite       = 1'b1;
            IFIDWrite     = 1'b1;
            IFIDFlush     = BranchTaken;
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst || StatClear) begin
      StallCycles <= '0;
    end else if (HazardControl && (StallCycles != STAT_MAX)) begin
      StallCycles <= StallCycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - self-checking bench for hazard_stall_controller
module tb_hazard_stall_controller;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [4:0] ID_Rs;
  logic [4:0] ID_Rt;
  logic       ID_UsesRt;
  logic       ID_MultiCycle;
  logic       EX_MemRead;
  logic [4:0] EX_WriteReg;
  logic       BranchTaken;
  logic       StatClear;

  logic        hc0, pcw0, ifw0, fl0, busy0;
  logic [15:0] st0;
  logic        hc1, pcw1, ifw1, fl1, busy1;
  logic [3:0]  st1;

  int checks = 0;
  int passed = 0;

  // Reference model state, one slot per instance: remaining hold cycles and
  // the stall statistic, tracked as plain integers.
  int lat[2]      = '{4, 1};
  int stat_max[2] = '{65535, 15};
  int m_hold[2];
  int m_stat[2];

  always #5 Clk = ~Clk;

  hazard_stall_controller #(.MC_LATENCY(4), .STAT_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_MultiCycle(ID_MultiCycle), .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg),
    .BranchTaken(BranchTaken), .StatClear(StatClear),
    .HazardControl(hc0), .PCWrite(pcw0), .IFIDWrite(ifw0), .IFIDFlush(fl0),
    .Busy(busy0), .StallCycles(st0)
  );

  hazard_stall_controller #(.MC_LATENCY(1), .STAT_W(4)) dut_l1 (
    .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_MultiCycle(ID_MultiCycle), .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg),
    .BranchTaken(BranchTaken), .StatClear(StatClear),
    .HazardControl(hc1), .PCWrite(pcw1), .IFIDWrite(ifw1), .IFIDFlush(fl1),
    .Busy(busy1), .StallCycles(st1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic bit load_use();
    bit dep;
    dep = (EX_WriteReg == ID_Rs) || (ID_UsesRt && EX_WriteReg == ID_Rt);
    return EX_MemRead && (EX_WriteReg != 0) && dep;
  endfunction

  // Expected control outputs for instance k from the current inputs.
  task automatic expect_outs(input int k, output bit hc, output bit pcw,
                             output bit ifw, output bit fl, output bit busy);
    hc = 1; pcw = 0; ifw = 0; fl = 0; busy = 0;
    if (Rst) return;
    if (m_hold[k] > 0) begin
      busy = 1;
    end else if (!load_use()) begin
      hc = 0; pcw = 1; ifw = 1; fl = BranchTaken;
    end
  endtask

  // Check all outputs mid-cycle, then advance the model across the edge.
  task automatic tick(input string tag);
    bit hc, pcw, ifw, fl, busy;
    bit hcv[2];
    bit lu_now, mc_now, rst_now, clr_now;
    @(negedge Clk);
    for (int k = 0; k < 2; k++) begin
      expect_outs(k, hc, pcw, ifw, fl, busy);
      hcv[k] = hc;
      if (k == 0) begin
        chk({tag, ".hc"}, 32'(hc0), 32'(hc));
        chk({tag, ".pcw"}, 32'(pcw0), 32'(pcw));
        chk({tag, ".ifw"}, 32'(ifw0), 32'(ifw));
        chk({tag, ".flush"}, 32'(fl0), 32'(fl));
        chk({tag, ".busy"}, 32'(busy0), 32'(busy));
        chk({tag, ".stat"}, 32'(st0), 32'(m_stat[0]));
      end else begin
        chk({tag, ".l1.hc"}, 32'(hc1), 32'(hc));
        chk({tag, ".l1.pcw"}, 32'(pcw1), 32'(pcw));
        chk({tag, ".l1.flush"}, 32'(fl1), 32'(fl));
        chk({tag, ".l1.busy"}, 32'(busy1), 32'(busy));
        chk({tag, ".l1.stat"}, 32'(st1), 32'(m_stat[1]));
      end
    end
    lu_now = load_use(); mc_now = ID_MultiCycle; rst_now = Rst; clr_now = StatClear;
    @(posedge Clk);
    for (int k = 0; k < 2; k++) begin
      if (rst_now) begin
        m_hold[k] = 0;
        m_stat[k] = 0;
      end else begin
        if (clr_now) m_stat[k] = 0;
        else if (hcv[k] && m_stat[k] < stat_max[k]) m_stat[k]++;
        if (m_hold[k] > 0) m_hold[k]--;
        else if (!lu_now && mc_now && lat[k] > 1) m_hold[k] = lat[k] - 1;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    Rst = 0; ID_Rs = 5'd1; ID_Rt = 5'd2; ID_UsesRt = 0; ID_MultiCycle = 0;
    EX_MemRead = 0; EX_WriteReg = 5'd0; BranchTaken = 0; StatClear = 0;
  endtask

  initial begin
    idle_inputs();
    m_hold = '{0, 0};
    m_stat = '{0, 0};
    Rst = 1;
    #1;
    tick("reset0");
    tick("reset1");
    chk("reset.stat", 32'(st0), 32'd0);
    idle_inputs();
    tick("idle");

    // Load-use: lw $5 in EX, ID reads $5.
    EX_MemRead = 1; EX_WriteReg = 5'd5; ID_Rs = 5'd5;
    tick("lu.stall");
    EX_MemRead = 0;
    tick("lu.release");
    chk("lu.stat_is_1", 32'(st0), 32'd1);

    // No false hazard on $0 or on an unused rt.
    EX_MemRead = 1; EX_WriteReg = 5'd0; ID_Rs = 5'd0;
    tick("nofalse.r0");
    EX_WriteReg = 5'd5; ID_Rs = 5'd3; ID_Rt = 5'd5; ID_UsesRt = 0;
    tick("nofalse.rt");
    ID_UsesRt = 1;
    tick("rt.hazard");
    idle_inputs();

    // Multi-cycle hold: one cycle in ID then three bubbles.
    ID_MultiCycle = 1;
    tick("mc.issue");
    ID_MultiCycle = 0;
    for (int i = 0; i < 3; i++) tick("mc.hold");
    chk("mc.busy_end", 32'(busy0), 32'd0);
    tick("mc.run");
    chk("mc.stat_is_5", 32'(st0), 32'd5);

    // Back-to-back multi-cycle ops.
    ID_MultiCycle = 1;
    for (int i = 0; i < 9; i++) tick("mc.b2b");
    idle_inputs();
    tick("mc.b2b.tail");
    for (int i = 0; i < 3; i++) tick("mc.b2b.drain");

    // Branch: flush in RUN, none while stalled, flush after the stall.
    BranchTaken = 1;
    tick("br.flush");
    BranchTaken = 0;
    tick("br.none");
    BranchTaken = 1; EX_MemRead = 1; EX_WriteReg = 5'd7; ID_Rs = 5'd7;
    tick("br.stalled");
    EX_MemRead = 0;
    tick("br.after_stall");
    idle_inputs();

    // Reset asserted in the second hold cycle.
    ID_MultiCycle = 1;
    tick("rst.issue");
    ID_MultiCycle = 0;
    tick("rst.hold1");
    Rst = 1;
    tick("rst.hold2");
    Rst = 0;
    tick("rst.after");
    chk("rst.after_pcw", 32'(pcw0), 32'd1);
    chk("rst.after_stat", 32'(st0), 32'd0);

    // Saturation of the 4-bit statistic across 20 stall cycles.
    EX_MemRead = 1; EX_WriteReg = 5'd9; ID_Rs = 5'd9;
    for (int i = 0; i < 20; i++) tick("sat.stall");
    chk("sat.l1_at_15", 32'(st1), 32'd15);
    chk("sat.main_at_20", 32'(st0), 32'd20);
    StatClear = 1;
    tick("sat.clear");
    StatClear = 0;
    tick("sat.cleared");
    StatClear = 1; Rst = 1;
    tick("rst_and_clear");
    idle_inputs();
    tick("rst_and_clear.after");
    chk("rst_and_clear.stat", 32'(st0), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      Rst           = ($urandom_range(0, 63) == 0);
      StatClear     = ($urandom_range(0, 31) == 0);
      ID_Rs         = 5'($urandom_range(0, 3));
      ID_Rt         = 5'($urandom_range(0, 3));
      ID_UsesRt     = 1'($urandom);
      ID_MultiCycle = ($urandom_range(0, 3) == 0);
      EX_MemRead    = 1'($urandom);
      EX_WriteReg   = 5'($urandom_range(0, 3));
      BranchTaken   = ($urandom_range(0, 2) == 0);
      tick("rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Pipeline stall and flush controller for the five-stage MIPS core. It drives the bubble-select line (`HazardControl`) of the ID/EX control bubble mux and the PC and IF/ID write/flush enables. It detects load-use hazards, sequences the fixed-latency hold required by multi-cycle EX operations (SAD, MADD/MSUB), squashes the fetched instruction on a taken branch, and keeps a saturating stall-cycle statistic.

## Interface
- `MC_LATENCY`, default 4: cycles a multi-cycle op needs before its result can be consumed; legal range 1..15.
- `STAT_W`, default 16: width of the stall-cycle counter.

Ports:
- `Clk`  in  1  core clock; all state updates on rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `ID_Rs`  in  5  rs field of the instruction in ID.
- `ID_Rt`  in  5  rt field of the instruction in ID.
- `ID_UsesRt`  in  1  the ID instruction reads rt as a source.
- `ID_MultiCycle`  in  1  the ID instruction is a multi-cycle EX op.
- `EX_MemRead`  in  1  the instruction in EX is a load.
- `EX_WriteReg`  in  5  destination register of the EX instruction.
- `BranchTaken`  in  1  branch/jump resolved taken in ID this cycle.
- `StatClear`  in  1  synchronous clear of `StallCycles`.
- `HazardControl`  out  1  1 = bubble mux zeroes ID/EX control.
- `PCWrite`  out  1  PC register write enable.
- `IFIDWrite`  out  1  IF/ID register write enable.
- `IFIDFlush`  out  1  IF/ID register loads NOP.
- `Busy`  out  1  FSM is in MC_HOLD.
- `StallCycles`  out  `STAT_W`  saturating count of bubble cycles.

## Operation
- Register state: FSM {RUN, MC_HOLD}, hold counter `cnt` (4 bits), `StallCycles`.
- Load-use hazard `lu` = `EX_MemRead` & (`EX_WriteReg` != 0) & ((`EX_WriteReg` == `ID_Rs`) | (`ID_UsesRt` & `EX_WriteReg` == `ID_Rt`)).
- RUN, `lu`=1: `HazardControl`=1, `PCWrite`=0, `IFIDWrite`=0, `IFIDFlush`=0. Remain in RUN; the following cycle re-evaluates `lu`, which is 0 because EX then holds a bubble.
- RUN, `lu`=0: `HazardControl`=0, `PCWrite`=1, `IFIDWrite`=1, `IFIDFlush`=`BranchTaken`.
  - If `ID_MultiCycle`=1 and `MC_LATENCY`>1, the FSM moves to MC_HOLD with `cnt`=`MC_LATENCY`-1.
- MC_HOLD: `HazardControl`=1, `PCWrite`=0, `IFIDWrite`=0, `IFIDFlush`=0, `Busy`=1.
  - `cnt` decrements each cycle; when `cnt`==1 the next state is RUN.
  - `lu`, `BranchTaken` and `ID_MultiCycle` are ignored during MC_HOLD.
- Priority: `Rst` > MC_HOLD > `lu` > `BranchTaken`.
- A branch in ID that is stalled is not flushed. It is re-evaluated when the stall releases.
- `StallCycles`: +1 on every cycle with `HazardControl`=1, saturating at 2^`STAT_W`-1. `StatClear` has priority over the increment and loads 0.
- With `MC_LATENCY`=1, a multi-cycle op behaves as a single-cycle op and the FSM never enters MC_HOLD.

## Timing
- Control outputs are combinational from state and inputs; they must settle within the same cycle for use by the PC and IF/ID enables.
- While `Rst`=1: `HazardControl`=1, `PCWrite`=0, `IFIDWrite`=0, `IFIDFlush`=0, `Busy`=0.
- After the first edge with `Rst`=1: state=RUN, `cnt`=0, `StallCycles`=0.
- Load-use penalty: exactly 1 bubble cycle.
- Multi-cycle penalty: exactly `MC_LATENCY`-1 bubble cycles, starting the cycle after the op leaves ID.
- Back-to-back multi-cycle ops: the second op enters EX on the first RUN cycle after the hold. It then incurs its own `MC_LATENCY`-1 hold, with no RUN cycles lost in between.
- `Rst` during MC_HOLD: the FSM is in RUN at the next edge and any remaining hold is discarded.
- `Rst` and `StatClear` together: the counter is 0.

## Test plan
- **Load-use:** EX=`lw $5` (`EX_MemRead`=1, `EX_WriteReg`=5), ID `ID_Rs`=5.
  - Required: one cycle with `HazardControl`=1, `PCWrite`=0, `IFIDWrite`=0; next cycle with `EX_MemRead`=0, all enables return to 1; `StallCycles`=1.
- **No false hazard:** `EX_WriteReg`=0 with `ID_Rs`=0, and `EX_WriteReg`=5 with `ID_Rt`=5 but `ID_UsesRt`=0.
  - Required: `HazardControl`=0 in both cases.
- **Multi-cycle hold:** `MC_LATENCY`=4, `ID_MultiCycle`=1 for one cycle in RUN.
  - Required: next 3 cycles `Busy`=1, `HazardControl`=1, `PCWrite`=0; 4th cycle is RUN; `StallCycles`=3.
- **Branch:** `BranchTaken`=1 in RUN with no hazard gives `IFIDFlush`=1 for 1 cycle.
  - `BranchTaken`=1 together with `lu`=1 gives `IFIDFlush`=0; the flush occurs the cycle after the stall.
- **Reset mid-hold:** assert `Rst` in the 2nd MC_HOLD cycle.
  - Required: during `Rst`, `PCWrite`=0 and `Busy`=0; after release, state=RUN, `StallCycles`=0, `PCWrite`=1.
- **Saturation:** `STAT_W`=4, 20 consecutive stall cycles.
  - Required: `StallCycles` holds at 15; `StatClear` then gives 0.
